// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I widths, opcode constants and immediate-format enum
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_AW = $clog2(NREG);
  localparam logic [6:0] OP = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
endpackage

// File: rtl/id_operand_stage_if.sv
// id_operand_stage_if: fetch->ID (in_*) and ID->EX (out_*) handshakes; master = environment, slave = stage
interface id_operand_stage_if;
  import rv32_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_imm;
  logic [REG_AW-1:0] out_rd;
  logic [6:0] out_opcode;
  logic [2:0] out_funct3;
  logic out_funct7b5;
  logic out_illegal;
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input in_ready, out_valid, out_pc, out_op1, out_op2, out_imm, out_rd, out_opcode, out_funct3,
    out_funct7b5, out_illegal
  );
  modport slave (
    input in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_op1, out_op2, out_imm, out_rd, out_opcode, out_funct3,
    out_funct7b5, out_illegal
  );
endinterface

// File: rtl/rv32_imm_gen.sv
// rv32_imm_gen: instr + imm_type in -> sign-extended XLEN immediate out (0 for IMM_NONE)
module rv32_imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_t imm_type,
  output logic [XLEN-1:0] imm
);
  always_comb
    imm = imm_type == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
          imm_type == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          imm_type == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          imm_type == IMM_U ? {instr[31:12], 12'b0} :
          imm_type == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
          '0;
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: RV32I decode/operand fetch; clk/rst, io (fetch in/ID-EX out handshakes), rf read ports, wb bypass, flush
module id_operand_stage
  import rv32_pkg::*;
(
  input  logic clk,
  input  logic rst,
  id_operand_stage_if.slave io,
  output logic [REG_AW-1:0] rf_a1,
  output logic [REG_AW-1:0] rf_a2,
  output logic rf_re1,
  output logic rf_re2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic flush
);
  logic [6:0] opc;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic is_op, is_imm, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic illegal, uses_rs1, uses_rs2, writes_rd, hit1, hit2, hazard, accept;
  logic [NREG-1:0] sb, sb_set, sb_clr;
  logic [XLEN-1:0] op1, op2, imm;
  imm_t imm_type;
  assign opc = io.in_instr[6:0];
  assign rs1 = io.in_instr[19:15];
  assign rs2 = io.in_instr[24:20];
  assign rd = io.in_instr[11:7];
  assign is_op = opc == OP;
  assign is_imm = opc == OP_IMM;
  assign is_ld = opc == LOAD;
  assign is_st = opc == STORE;
  assign is_br = opc == BRANCH;
  assign is_jal = opc == JAL;
  assign is_jalr = opc == JALR;
  assign is_lui = opc == LUI;
  assign is_auipc = opc == AUIPC;
  assign illegal = !(is_op || is_imm || is_ld || is_st || is_br || is_jal || is_jalr || is_lui || is_auipc);
  assign uses_rs1 = is_op || is_imm || is_ld || is_st || is_br || is_jalr;
  assign uses_rs2 = is_op || is_st || is_br;
  assign writes_rd = (is_op || is_imm || is_ld || is_lui || is_auipc || is_jal || is_jalr) && rd != '0;
  assign imm_type = (is_imm || is_ld || is_jalr) ? IMM_I :
                    is_st ? IMM_S :
                    is_br ? IMM_B :
                    (is_lui || is_auipc) ? IMM_U :
                    is_jal ? IMM_J : IMM_NONE;
  // The register file writes at the edge, so a same-cycle writeback must be forwarded here.
  assign hit1 = wb_we && wb_rd != '0 && wb_rd == rs1;
  assign hit2 = wb_we && wb_rd != '0 && wb_rd == rs2;
  assign op1 = rs1 == '0 ? '0 : hit1 ? wb_data : rf_rd1;
  assign op2 = rs2 == '0 ? '0 : hit2 ? wb_data : rf_rd2;
  assign hazard = (uses_rs1 && rs1 != '0 && sb[rs1] && !hit1) || (uses_rs2 && rs2 != '0 && sb[rs2] && !hit2);
  assign io.in_ready = !hazard && (!io.out_valid || io.out_ready) && !flush;
  assign accept = io.in_valid && io.in_ready;
  assign rf_a1 = rs1;
  assign rf_a2 = rs2;
  assign rf_re1 = io.in_valid && uses_rs1;
  assign rf_re2 = io.in_valid && uses_rs2;
  assign sb_set = (accept && writes_rd) ? NREG'(1) << rd : '0;
  assign sb_clr = wb_we ? NREG'(1) << wb_rd : '0;
  rv32_imm_gen u_imm (.instr(io.in_instr), .imm_type(imm_type), .imm(imm));
  always_ff @(posedge clk) begin
    if (rst) begin
      io.out_valid <= 1'b0;
      io.out_pc <= '0;
      io.out_op1 <= '0;
      io.out_op2 <= '0;
      io.out_imm <= '0;
      io.out_rd <= '0;
      io.out_opcode <= '0;
      io.out_funct3 <= '0;
      io.out_funct7b5 <= 1'b0;
      io.out_illegal <= 1'b0;
      sb <= '0;
    end else if (flush) begin
      io.out_valid <= 1'b0;
      sb <= '0;
    end else begin
      // set after clear so a same-register set/clear collision keeps the bit
      sb <= ((sb & ~sb_clr) | sb_set) & ~NREG'(1);
      if (accept) begin
        io.out_valid <= 1'b1;
        io.out_pc <= io.in_pc;
        io.out_op1 <= op1;
        io.out_op2 <= op2;
        io.out_imm <= imm;
        io.out_rd <= writes_rd ? rd : '0;
        io.out_opcode <= opc;
        io.out_funct3 <= io.in_instr[14:12];
        io.out_funct7b5 <= io.in_instr[30];
        io.out_illegal <= illegal;
      end else if (io.out_ready) io.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed plan plus randomized run against a rule-level model of the stage
module tb_id_operand_stage;
  import rv32_pkg::*;
  typedef struct packed {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0] rd;
    logic [6:0] opc;
    logic [2:0] f3;
    logic f7, ill;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  id_operand_stage_if io ();
  logic [4:0] rf_a1, rf_a2, wb_rd;
  logic rf_re1, rf_re2, wb_we, flush;
  logic [31:0] rf_rd1, rf_rd2, wb_data;
  logic [31:0] regs [32];
  assign rf_rd1 = regs[rf_a1];
  assign rf_rd2 = regs[rf_a2];
  id_operand_stage dut (
    .clk(clk), .rst(rst), .io(io), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_re1(rf_re1), .rf_re2(rf_re2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );
  int tests = 0;
  int fails = 0;
  bit m_valid;
  rec_t m_out;
  bit [31:0] pend;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void dec(input logic [31:0] i, input logic [31:0] pc, output rec_t r,
                              output bit u1, output bit u2, output bit wr);
    logic signed [31:0] s;
    r = '0;
    u1 = 0; u2 = 0; wr = 0;
    r.pc = pc; r.opc = i[6:0]; r.f3 = i[14:12]; r.f7 = i[30];
    case (i[6:0])
      7'h33: begin u1 = 1; u2 = 1; wr = 1; end
      7'h13, 7'h03, 7'h67: begin u1 = 1; wr = 1; s = $signed({i[31:20], 20'h0}) >>> 20; r.imm = s; end
      7'h23: begin u1 = 1; u2 = 1; s = $signed({i[31:25], i[11:7], 20'h0}) >>> 20; r.imm = s; end
      7'h63: begin u1 = 1; u2 = 1; s = $signed({i[31], i[7], i[30:25], i[11:8], 20'h0}) >>> 19; r.imm = s; end
      7'h37, 7'h17: begin wr = 1; r.imm = {i[31:12], 12'h0}; end
      7'h6f: begin wr = 1; s = $signed({i[31], i[19:12], i[20], i[30:21], 12'h0}) >>> 11; r.imm = s; end
      default: r.ill = 1;
    endcase
    wr = wr && i[11:7] != 0;
    r.rd = wr ? i[11:7] : 5'd0;
  endfunction
  task automatic cycle(output bit acc);
    rec_t r;
    bit u1, u2, wr, hz, er;
    logic [4:0] s1, s2;
    #1;
    dec(io.in_instr, io.in_pc, r, u1, u2, wr);
    s1 = io.in_instr[19:15];
    s2 = io.in_instr[24:20];
    r.op1 = s1 == 0 ? 32'd0 : (wb_we && wb_rd == s1) ? wb_data : regs[s1];
    r.op2 = s2 == 0 ? 32'd0 : (wb_we && wb_rd == s2) ? wb_data : regs[s2];
    hz = (u1 && s1 != 0 && pend[s1] && !(wb_we && wb_rd == s1)) || (u2 && s2 != 0 && pend[s2] && !(wb_we && wb_rd == s2));
    er = !hz && (!m_valid || io.out_ready) && !flush;
    acc = !rst && io.in_valid && er;
    if (!rst) begin
      chk("in_ready", io.in_ready, er);
      chk("rf_a1", rf_a1, s1);
      chk("rf_a2", rf_a2, s2);
      chk("rf_re1", rf_re1, io.in_valid && u1);
      chk("rf_re2", rf_re2, io.in_valid && u2);
      chk("out_valid", io.out_valid, m_valid);
      chk("scoreboard", dut.sb, pend);
      if (m_valid) begin
        chk("out_pc", io.out_pc, m_out.pc);
        chk("out_op1", io.out_op1, m_out.op1);
        chk("out_op2", io.out_op2, m_out.op2);
        chk("out_imm", io.out_imm, m_out.imm);
        chk("out_rd", io.out_rd, m_out.rd);
        chk("out_opcode", io.out_opcode, m_out.opc);
        chk("out_funct3", io.out_funct3, m_out.f3);
        chk("out_funct7b5", io.out_funct7b5, m_out.f7);
        chk("out_illegal", io.out_illegal, m_out.ill);
      end
    end
    @(posedge clk);
    #1;
    if (rst || flush) begin
      m_valid = 0;
      pend = 0;
    end else begin
      if (acc) begin m_out = r; m_valid = 1; end
      else if (io.out_ready) m_valid = 0;
      if (wb_we && wb_rd != 0) pend[wb_rd] = 0;
      if (acc && wr) pend[r.rd] = 1;
    end
    if (wb_we && wb_rd != 0) regs[wb_rd] = wb_data;
  endtask
  task automatic issue(input logic [31:0] instr);
    io.in_instr = instr;
    io.in_pc = io.in_pc + 4;
  endtask
  logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f};
  initial begin
    bit acc;
    logic [31:0] ins;
    regs[0] = 0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    io.in_valid = 0; io.in_instr = 0; io.in_pc = 32'h1000; io.out_ready = 1;
    wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0;
    cycle(acc);
    cycle(acc);
    rst = 0;
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_out_pc", io.out_pc, 0);
    chk("rst_out_op1", io.out_op1, 0);
    chk("rst_out_rd", io.out_rd, 0);
    chk("rst_sb", dut.sb, 0);
    io.in_valid = 1; issue(32'h00700293);
    cycle(acc);
    chk("t1_valid", io.out_valid, 1);
    chk("t1_op1", io.out_op1, 0);
    chk("t1_imm", io.out_imm, 7);
    chk("t1_rd", io.out_rd, 5);
    chk("t1_sb5", dut.sb[5], 1);
    issue(32'h00528333);
    #1 chk("t2_stall", io.in_ready, 0);
    wb_we = 1; wb_rd = 5; wb_data = 7;
    #1 chk("t2_bypass_ready", io.in_ready, 1);
    cycle(acc);
    wb_we = 0;
    chk("t2_op1", io.out_op1, 7);
    chk("t2_op2", io.out_op2, 7);
    issue(32'h00300393);
    io.out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(acc);
      chk("t3_hold_ready", io.in_ready, 0);
      chk("t3_hold_rd", io.out_rd, 6);
    end
    io.out_ready = 1;
    cycle(acc);
    chk("t3_load_rd", io.out_rd, 7);
    chk("t3_load_imm", io.out_imm, 3);
    io.in_valid = 0;
    cycle(acc);
    chk("t3_no_dup", io.out_valid, 0);
    io.in_valid = 1; issue(32'h00100293);
    cycle(acc);
    issue(32'h00200293);
    wb_we = 1; wb_rd = 5; wb_data = 9;
    cycle(acc);
    chk("t4_collide_sb5", dut.sb[5], 1);
    chk("t4_imm", io.out_imm, 2);
    wb_rd = 7;
    issue(32'hFE000EE3);
    cycle(acc);
    wb_we = 0;
    chk("t5_sb56", dut.sb, 32'h60);
    chk("t6_beq_imm", io.out_imm, 32'hFFFFFFFC);
    flush = 1;
    issue(32'h00100413);
    #1 chk("t5_flush_ready", io.in_ready, 0);
    cycle(acc);
    flush = 0;
    io.in_valid = 0;
    chk("t5_flush_valid", io.out_valid, 0);
    chk("t5_flush_sb", dut.sb, 0);
    io.in_valid = 1; issue(32'h123450B7);
    cycle(acc);
    chk("t6_lui_imm", io.out_imm, 32'h12345000);
    issue(32'h0000057F);
    cycle(acc);
    chk("t6_illegal", io.out_illegal, 1);
    chk("t6_illegal_rd", io.out_rd, 0);
    chk("t6_illegal_sb", dut.sb[10], 0);
    acc = 1;
    for (int n = 0; n < 3000; n++) begin
      if (acc || !io.in_valid) begin
        ins = $urandom;
        ins[6:0] = opcs[$urandom_range(0, 9)];
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        ins[11:7] = 5'($urandom_range(0, 7));
        issue(ins);
        io.in_valid = $urandom_range(0, 3) != 0;
      end
      io.out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 39) == 0;
      wb_we = $urandom_range(0, 2) == 0;
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      cycle(acc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode/operand-fetch stage; sits directly upstream of the 32x32 register file.
- Takes fetched RV32I instructions and drives the register file read addresses and read enables. Consumes RD1/RD2, with a same-cycle writeback bypass.
- Tracks outstanding destination writes in a scoreboard and stalls on RAW hazards.
- Registers decoded operands into an ID/EX pipeline register with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, data/PC width
- NREG, 32, architectural registers (address width log2(NREG)=5)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- rf_a1  out  5  register file read address 1 (= instr[19:15])
- rf_a2  out  5  register file read address 2 (= instr[24:20])
- rf_re1  out  1  read enable 1 (= in_valid & uses_rs1)
- rf_re2  out  1  read enable 2 (= in_valid & uses_rs2)
- rf_rd1  in  XLEN  register file read data 1
- rf_rd2  in  XLEN  register file read data 2
- wb_we  in  1  writeback write enable (same signal drives register file WE3)
- wb_rd  in  5  writeback address
- wb_data  in  XLEN  writeback data
- flush  in  1  kill stage contents and all in-flight instructions
- out_valid  out  1  ID/EX register holds instruction
- out_ready  in  1  execute accepts
- out_pc, out_op1, out_op2, out_imm  out  XLEN  registered PC, operands, immediate
- out_rd  out  5  destination (0 if none)
- out_opcode  out  7  opcode field
- out_funct3  out  3  funct3 field
- out_funct7b5  out  1  instr[30]
- out_illegal  out  1  opcode not RV32I base

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. On rst, out_valid=0, all out_* data=0, scoreboard=0.
- Decode (combinational on in_instr):
  - uses_rs1 for R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - uses_rs2 for R, STORE, BRANCH.
  - writes_rd for R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR, and only when rd!=0.
  - Unknown opcode: illegal=1, uses/writes all 0.
- Immediates per type I/S/B/U/J, sign-extended to XLEN; R-type imm=0.
- Bypass: op = 0 if rs==0; else wb_data if wb_we & wb_rd==rs; else rf_rdN. Needed because the register file writes at the edge and reads combinationally.
- Hazard: (uses_rs1 & rs1!=0 & sb[rs1] & !(wb_we & wb_rd==rs1)) | the same for rs2.
- in_ready = !hazard & (!out_valid | out_ready) & !flush.
- Accept (in_valid & in_ready): ID/EX register loads at the next edge and out_valid=1. Latency 1 cycle.
- Hold: out_valid & !out_ready keeps all outputs stable.
- Drain: out_valid & out_ready & no accept sets out_valid=0.
- Scoreboard, a NREG-bit vector:
  - Set sb[rd] on accept with writes_rd.
  - Clear sb[wb_rd] on wb_we.
  - Same rd set and cleared in one cycle: set wins.
  - Bit 0 is never set.
- Flush (priority below rst, above everything else): out_valid=0 and scoreboard cleared at the next edge, no accept that cycle. Contract: flush kills all in-flight downstream writers.
- Illegal instruction is accepted and passed with out_illegal=1, out_rd=0, no scoreboard set.
- wb_we with wb_rd=0: ignored for bypass and scoreboard.

Decomposition:
- Shared package rv32_pkg:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - immediate-type enum (IMM_I/S/B/U/J/NONE)
  - XLEN, REG_AW
- Sub-module rv32_imm_gen: instr + type -> sign-extended immediate.
- Decode, bypass, scoreboard and pipeline register stay in id_operand_stage.

Test Plan:
1. rst held 2 cycles, then released -> out_valid=0, in_ready=1. Issue ADDI x5,x0,7 (0x00700293) -> next cycle out_valid=1, out_op1=0, out_imm=7, out_rd=5, sb[5]=1.
2. Scoreboard stall: after test 1, present ADD x6,x5,x5 -> in_ready=0. Drive wb_we=1, wb_rd=5, wb_data=7 -> in_ready=1 that cycle; out_op1=out_op2=7 next cycle via bypass.
3. Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. out_ready=1 -> next instruction loads in 1 cycle, no loss or duplication.
4. Set/clear collision: sb[5]=1; accept ADDI x5,... while wb_we=1, wb_rd=5 -> sb[5] remains 1.
5. Flush with out_valid=1 and sb={5,6} -> next cycle out_valid=0, sb=0, instruction offered during flush not accepted.
6. Immediates: BEQ imm=-4 gives out_imm=0xFFFFFFFC. LUI 0x12345 gives out_imm=0x12345000. Opcode 0x7F gives out_illegal=1, out_rd=0.
